// File: rtl/procyon_lib_pkg.sv
// Shared helpers for the procyon slot-tracking blocks: index-width macro, popcount.
`ifndef PCYN_C2I
`define PCYN_C2I(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package procyon_lib_pkg;

  localparam int PCYN_MAX_VEC_W = 64;

  typedef logic [PCYN_MAX_VEC_W-1:0] pcyn_vec_t;

  function automatic int pcyn_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int pcyn_popcount(input pcyn_vec_t vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < PCYN_MAX_VEC_W; i++) begin
      cnt = cnt + int'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/procyon_priority_picker.sv
// First-set-bit picker over a request vector, searching upward from a rotate offset.
module procyon_priority_picker
  import procyon_lib_pkg::*;
#(
  parameter int OPTN_WIDTH  = 8,
  parameter int OPTN_ROTATE = 0
) (
  input  logic [OPTN_WIDTH-1:0]                 i_req,
  input  logic [`PCYN_C2I(OPTN_WIDTH)-1:0]      i_offset,
  output logic                                  o_valid,
  output logic [`PCYN_C2I(OPTN_WIDTH)-1:0]      o_idx,
  output logic [OPTN_WIDTH-1:0]                 o_onehot
);

  localparam int IDX_W = `PCYN_C2I(OPTN_WIDTH);

  logic [IDX_W-1:0] w_offset;

  assign w_offset = (OPTN_ROTATE != 0) ? i_offset : '0;

  // Offset is assumed < OPTN_WIDTH, so a single subtract is enough to wrap.
  always_comb begin
    int j;
    j       = 0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < OPTN_WIDTH; k++) begin
      j = int'(w_offset) + k;
      if (j >= OPTN_WIDTH) j = j - OPTN_WIDTH;
      if (!o_valid && i_req[j]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    o_onehot = '0;
    if (o_valid) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/procyon_slot_allocator.sv
// Busy/free tracker for a tag pool: one grant per cycle, several frees per cycle.
// PCYN_SLOT_ALLOC_ROUND_ROBIN_EN selects round-robin search; default is lowest-index-first.
module procyon_slot_allocator
  import procyon_lib_pkg::*;
#(
  parameter int OPTN_NUM_SLOTS  = 8,
  parameter int OPTN_FREE_PORTS = 2
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              i_alloc_req,
  output logic                                              o_alloc_gnt,
  output logic [`PCYN_C2I(OPTN_NUM_SLOTS)-1:0]              o_alloc_idx,
  output logic [OPTN_NUM_SLOTS-1:0]                         o_alloc_onehot,
  input  logic [OPTN_FREE_PORTS-1:0]                        i_free_en,
  input  logic [OPTN_FREE_PORTS*`PCYN_C2I(OPTN_NUM_SLOTS)-1:0] i_free_idx,
  output logic [OPTN_NUM_SLOTS-1:0]                         o_busy_mask,
  output logic [`PCYN_C2I(OPTN_NUM_SLOTS+1)-1:0]            o_busy_count,
  output logic                                              o_full,
  output logic                                              o_empty
);

  localparam int IDX_W = `PCYN_C2I(OPTN_NUM_SLOTS);
  localparam int CNT_W = `PCYN_C2I(OPTN_NUM_SLOTS+1);

  logic [OPTN_NUM_SLOTS-1:0] w_free_mask;
  logic [OPTN_NUM_SLOTS-1:0] w_busy_next;
  logic [OPTN_NUM_SLOTS-1:0] w_pick_onehot;
  logic                      w_pick_valid;
  logic [IDX_W-1:0]          w_pick_idx;
  logic [IDX_W-1:0]          w_offset;

`ifdef PCYN_SLOT_ALLOC_ROUND_ROBIN_EN
  localparam int ROTATE = 1;

  logic [IDX_W-1:0] r_rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (o_alloc_gnt) begin
      r_rr_ptr <= (o_alloc_idx == IDX_W'(OPTN_NUM_SLOTS-1)) ? '0 : o_alloc_idx + 1'b1;
    end
  end

  assign w_offset = r_rr_ptr;
`else
  localparam int ROTATE = 0;

  assign w_offset = '0;
`endif

  procyon_priority_picker #(
    .OPTN_WIDTH  (OPTN_NUM_SLOTS),
    .OPTN_ROTATE (ROTATE)
  ) u_picker (
    .i_req    (~o_busy_mask),
    .i_offset (w_offset),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx),
    .o_onehot (w_pick_onehot)
  );

  assign o_alloc_gnt    = i_alloc_req & ~o_full & w_pick_valid;
  assign o_alloc_idx    = o_alloc_gnt ? w_pick_idx : '0;
  assign o_alloc_onehot = o_alloc_gnt ? w_pick_onehot : '0;

  // Out-of-range indices match no slot and so drop out naturally.
  always_comb begin
    w_free_mask = '0;
    for (int p = 0; p < OPTN_FREE_PORTS; p++) begin
      for (int s = 0; s < OPTN_NUM_SLOTS; s++) begin
        if (i_free_en[p] && (int'(i_free_idx[p*IDX_W +: IDX_W]) == s)) w_free_mask[s] = 1'b1;
      end
    end
  end

  assign w_busy_next = (o_busy_mask | o_alloc_onehot) & ~w_free_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_busy_mask  <= '0;
      o_busy_count <= '0;
      o_full       <= 1'b0;
      o_empty      <= 1'b1;
    end else begin
      o_busy_mask  <= w_busy_next;
      o_busy_count <= CNT_W'(pcyn_popcount(pcyn_vec_t'(w_busy_next)));
      o_full       <= &w_busy_next;
      o_empty      <= ~|w_busy_next;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((w_free_mask & ~o_busy_mask) == '0)
        else $warning("slot allocator: free of idle slot ignored");
    end
  end
`endif

endmodule

// File: tb/tb_procyon_slot_allocator.sv
// Directed bench for procyon_slot_allocator: an 8-slot and a 6-slot instance.
module tb_procyon_slot_allocator;

`ifdef PCYN_SLOT_ALLOC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;

  logic       req8, gnt8;
  logic [2:0] idx8;
  logic [7:0] oh8;
  logic [1:0] fen8;
  logic [5:0] fidx8;
  logic [7:0] mask8;
  logic [3:0] cnt8;
  logic       full8, empty8;

  logic       req6, gnt6;
  logic [2:0] idx6;
  logic [5:0] oh6;
  logic [1:0] fen6;
  logic [5:0] fidx6;
  logic [5:0] mask6;
  logic [2:0] cnt6;
  logic       full6, empty6;

  int checks = 0;
  int errors = 0;

  procyon_slot_allocator #(.OPTN_NUM_SLOTS(8), .OPTN_FREE_PORTS(2)) u_dut8 (
    .clk(clk), .rst(rst), .i_alloc_req(req8), .o_alloc_gnt(gnt8), .o_alloc_idx(idx8),
    .o_alloc_onehot(oh8), .i_free_en(fen8), .i_free_idx(fidx8), .o_busy_mask(mask8),
    .o_busy_count(cnt8), .o_full(full8), .o_empty(empty8)
  );

  procyon_slot_allocator #(.OPTN_NUM_SLOTS(6), .OPTN_FREE_PORTS(2)) u_dut6 (
    .clk(clk), .rst(rst), .i_alloc_req(req6), .o_alloc_gnt(gnt6), .o_alloc_idx(idx6),
    .o_alloc_onehot(oh6), .i_free_en(fen6), .i_free_idx(fidx6), .o_busy_mask(mask6),
    .o_busy_count(cnt6), .o_full(full6), .o_empty(empty6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req8 = 1'b0; fen8 = '0; fidx8 = '0;
    req6 = 1'b0; fen6 = '0; fidx6 = '0;
    tick();
    tick();
    chk("rst_mask", 32'(mask8), 32'h0);
    chk("rst_cnt", 32'(cnt8), 32'd0);
    chk("rst_full", 32'(full8), 32'd0);
    chk("rst_empty", 32'(empty8), 32'd1);
    chk("rst6_empty", 32'(empty6), 32'd1);
    rst = 1'b0;

    // fill all eight slots back to back
    for (int i = 0; i < 8; i++) begin
      req8 = 1'b1;
      #1;
      chk($sformatf("fill_gnt%0d", i), 32'(gnt8), 32'd1);
      chk($sformatf("fill_idx%0d", i), 32'(idx8), 32'(i));
      chk($sformatf("fill_oh%0d", i), 32'(oh8), 32'd1 << i);
      tick();
      chk($sformatf("fill_full%0d", i), 32'(full8), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("fill_cnt", 32'(cnt8), 32'd8);
    chk("fill_mask", 32'(mask8), 32'hff);
    chk("fill_empty", 32'(empty8), 32'd0);
    #1;
    chk("full_gnt", 32'(gnt8), 32'd0);
    chk("full_idx", 32'(idx8), 32'd0);
    chk("full_oh", 32'(oh8), 32'd0);

    // full: free 3 and 5 while requesting
    fen8 = 2'b11; fidx8 = {3'd5, 3'd3};
    #1;
    chk("fullfree_gnt", 32'(gnt8), 32'd0);
    tick();
    fen8 = '0;
    chk("fullfree_cnt", 32'(cnt8), 32'd6);
    chk("fullfree_mask", 32'(mask8), 32'hd7);
    chk("fullfree_full", 32'(full8), 32'd0);
    #1;
    chk("refill_gnt", 32'(gnt8), 32'd1);
    chk("refill_idx", 32'(idx8), 32'd3);
    tick();
    req8 = 1'b0;
    chk("refill_mask", 32'(mask8), 32'hdf);
    chk("refill_cnt", 32'(cnt8), 32'd7);

    // duplicate free on both ports
    fen8 = 2'b11; fidx8 = {3'd2, 3'd2};
    tick();
    chk("dup_cnt", 32'(cnt8), 32'd6);
    chk("dup_mask", 32'(mask8), 32'hdb);
    fen8 = 2'b01; fidx8 = {3'd0, 3'd6};
    tick();
    chk("free6_mask", 32'(mask8), 32'h9b);
    chk("free6_cnt", 32'(cnt8), 32'd5);
    tick();
    fen8 = '0;
    chk("idle6_mask", 32'(mask8), 32'h9b);
    chk("idle6_cnt", 32'(cnt8), 32'd5);

    // reset wins over request and frees
    rst = 1'b1; req8 = 1'b1; fen8 = 2'b11; fidx8 = {3'd1, 3'd0};
    tick();
    chk("rstact_mask", 32'(mask8), 32'h0);
    chk("rstact_cnt", 32'(cnt8), 32'd0);
    chk("rstact_empty", 32'(empty8), 32'd1);
    chk("rstact_full", 32'(full8), 32'd0);
    rst = 1'b0; req8 = 1'b0; fen8 = '0;

    // search order after a free behind the pointer
    req8 = 1'b1;
    #1;
    chk("ord_idx0", 32'(idx8), 32'd0);
    tick();
    #1;
    chk("ord_idx1", 32'(idx8), 32'd1);
    tick();
    req8 = 1'b0; fen8 = 2'b01; fidx8 = {3'd0, 3'd0};
    tick();
    fen8 = '0;
    chk("ord_mask", 32'(mask8), 32'h02);
    req8 = 1'b1;
    #1;
    chk("ord_idx2", 32'(idx8), RR ? 32'd2 : 32'd0);
    tick();
    fen8 = 2'b01; fidx8 = {3'd0, 3'd1};
    #1;
    chk("gntfree_idx", 32'(idx8), RR ? 32'd3 : 32'd2);
    tick();
    req8 = 1'b0; fen8 = '0;
    chk("gntfree_cnt", 32'(cnt8), 32'd2);
    chk("gntfree_mask", 32'(mask8), RR ? 32'h0c : 32'h05);

    // six-slot pool: indices 6 and 7 never valid
    for (int i = 0; i < 6; i++) begin
      req6 = 1'b1;
      #1;
      chk($sformatf("n6_idx%0d", i), 32'(idx6), 32'(i));
      tick();
    end
    chk("n6_full", 32'(full6), 32'd1);
    chk("n6_cnt", 32'(cnt6), 32'd6);
    #1;
    chk("n6_fullgnt", 32'(gnt6), 32'd0);
    req6 = 1'b0; fen6 = 2'b11; fidx6 = {3'd6, 3'd7};
    tick();
    fen6 = '0;
    chk("n6_oob_mask", 32'(mask6), 32'h3f);
    chk("n6_oob_cnt", 32'(cnt6), 32'd6);
    fen6 = 2'b01; fidx6 = {3'd0, 3'd5};
    tick();
    fen6 = '0;
    chk("n6_free5_cnt", 32'(cnt6), 32'd5);
    req6 = 1'b1;
    #1;
    chk("n6_regnt", 32'(gnt6), 32'd1);
    chk("n6_reidx", 32'(idx6), 32'd5);
    tick();
    req6 = 1'b0;
    chk("n6_refull", 32'(full6), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
